// File: rtl/button_event_pkg.sv
// Shared types and timing defaults for the per-button event decoder.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } btn_state_t;

    localparam int BTN_LONG_CYCLES_DEF   = 50_000_000;
    localparam int BTN_REPEAT_CYCLES_DEF = 10_000_000;

    // The counter must reach the larger of the two limits that are actually used.
    function automatic int btn_cnt_width(input int long_cycles, input int repeat_cycles,
                                         input bit repeat_en);
        int span;
        span = (repeat_en && (repeat_cycles > long_cycles)) ? repeat_cycles : long_cycles;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Turns debounced button activity into short-press, long-press and auto-repeat pulses.
// Auto-repeat is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_ff,
    input  logic valid_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic long_held
);

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam int CNT_W = btn_cnt_width(LONG_CYCLES, REPEAT_CYCLES, REPEAT_EN);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    btn_state_t       r_state;
    btn_state_t       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic             w_short;
    logic             w_long;
    logic             w_repeat;

    // Release is tested before the threshold so a release on the threshold edge stays short.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_pulse) begin
                    w_stateNext = PRESSED;
                    w_cntNext   = '0;
                end
            end
            PRESSED: begin
                if (!valid_ff) begin
                    w_short     = 1'b1;
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_long      = 1'b1;
                    w_stateNext = LONG;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            LONG: begin
                if (!valid_ff) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (r_cnt == REPEAT_LAST) begin
                        w_repeat  = 1'b1;
                        w_cntNext = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
`else
                    w_cntNext = '0;
`endif
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_short  <= w_short;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_held   <= (w_stateNext == LONG);
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign repeat_pulse = r_repeat;
    assign long_held    = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// The reference model tracks edges elapsed since the press start and applies the timing rules arithmetically.
module tb_button_event_decoder;

    localparam int L = 8;
    localparam int R = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_ff = 1'b0;
    logic valid_pulse = 1'b0;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic long_held;

    int checks = 0;
    int errors = 0;

    button_event_decoder #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_ff     (valid_ff),
        .valid_pulse  (valid_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .long_held    (long_held)
    );

    always #10 clk = ~clk;

    wire logic [3:0] outVec = {short_pulse, long_pulse, repeat_pulse, long_held};

    // Model: {short, long, repeat, held} expected after each edge; mN = edges since press start.
    logic [3:0] expVec;
    bit         mActive;
    int         mN;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mActive <= 1'b0;
            mN      <= 0;
            expVec  <= 4'b0000;
        end else if (!mActive) begin
            expVec <= 4'b0000;
            if (valid_pulse) begin
                mActive <= 1'b1;
                mN      <= 0;
            end
        end else if (!valid_ff) begin
            mActive <= 1'b0;
            expVec  <= {(mN + 1 <= L), 3'b000};
        end else begin
            mN     <= mN + 1;
            expVec <= {1'b0, (mN + 1 == L),
                       REP && (mN + 1 > L) && (((mN + 1 - L) % R) == 0),
                       (mN + 1 >= L)};
        end
    end

    task automatic tick(input logic vf, input logic vp);
        valid_ff    = vf;
        valid_pulse = vp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #5;
        checks++;
        if (outVec !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_hold got %b exp 0000", outVec);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (outVec !== 4'b0000 || outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL idle cyc%0d got %b exp 0000", i, outVec);
            end
        end
    endtask

    task automatic test_short_press();
        int shortCnt = 0;
        int longCnt = 0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick((i < 3) ? 1'b1 : 1'b0, 1'b0);
            shortCnt += short_pulse;
            longCnt  += long_pulse;
            checks++;
            if (outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL short_press cyc%0d got %b exp %b", i, outVec, expVec);
            end
            if (i == 3) begin
                checks++;
                if (outVec !== 4'b1000) begin
                    errors++;
                    $display("[TB] FAIL short_press_edge got %b exp 1000", outVec);
                end
            end
        end
        checks++;
        if (shortCnt != 1 || longCnt != 0) begin
            errors++;
            $display("[TB] FAIL short_count got short=%0d long=%0d exp short=1 long=0", shortCnt, longCnt);
        end
    endtask

    task automatic test_long_press();
        int longAt = -1;
        int firstRep = -1;
        int repCnt = 0;
        tick(1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 1'b0);
            if (long_pulse) longAt = k;
            if (repeat_pulse) begin
                repCnt++;
                if (firstRep < 0) firstRep = k;
            end
            checks++;
            if (outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL long_press k=%0d got %b exp %b", k, outVec, expVec);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (long_held !== (k == 8)) begin
                    errors++;
                    $display("[TB] FAIL long_held_rise k=%0d got %b exp %b", k, long_held, (k == 8));
                end
            end
        end
        tick(1'b0, 1'b0);
        checks++;
        if (outVec !== 4'b0000 || outVec !== expVec) begin
            errors++;
            $display("[TB] FAIL long_release got %b exp 0000", outVec);
        end
        checks++;
        if (longAt != L || repCnt != (REP ? 3 : 0) || (REP && firstRep != L + R)) begin
            errors++;
            $display("[TB] FAIL long_timing got long@%0d reps=%0d first@%0d exp long@%0d reps=%0d first@%0d",
                     longAt, repCnt, firstRep, L, (REP ? 3 : 0), L + R);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_release_at_threshold();
        tick(1'b1, 1'b1);
        for (int k = 1; k <= L; k++) begin
            tick((k < L) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL threshold_release k=%0d got %b exp %b", k, outVec, expVec);
            end
        end
        checks++;
        if (outVec !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL threshold_release_wins got %b exp 1000", outVec);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_press();
        tick(1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if (outVec !== 4'b0000 || outVec !== expVec) begin
            errors++;
            $display("[TB] FAIL mid_reset got %b exp 0000", outVec);
        end
        #5;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (outVec !== 4'b0000 || outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL held_after_reset cyc%0d got %b exp 0000", k, outVec);
            end
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (outVec !== 4'b1000 || outVec !== expVec) begin
            errors++;
            $display("[TB] FAIL press_after_reset got %b exp 1000", outVec);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_extra_pulse();
        int longAt = -1;
        tick(1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1, (k == 4) ? 1'b1 : 1'b0);
            if (long_pulse) longAt = k;
            checks++;
            if (outVec !== expVec) begin
                errors++;
                $display("[TB] FAIL extra_pulse k=%0d got %b exp %b", k, outVec, expVec);
            end
        end
        checks++;
        if (longAt != L) begin
            errors++;
            $display("[TB] FAIL extra_pulse_long got long@%0d exp long@%0d", longAt, L);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            int hold = $urandom_range(1, 22);
            int gap = $urandom_range(1, 4);
            tick(1'b1, 1'b1);
            for (int k = 1; k <= hold + gap; k++) begin
                if (k < hold) tick(1'b1, ($urandom_range(0, 7) == 0));
                else if (k == hold) tick(1'b0, 1'b0);
                else tick(1'($urandom_range(0, 1)), 1'b0);
                checks++;
                if (outVec !== expVec) begin
                    errors++;
                    $display("[TB] FAIL random p=%0d k=%0d got %b exp %b", p, k, outVec, expVec);
                end
            end
            tick(1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_release_at_threshold();
        test_reset_mid_press();
        test_extra_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies debounced button activity into discrete user events for the digital clock's time-setting logic. Consumes the level and pulse outputs of the debounce block and emits one-cycle pulses for short press, long press and auto-repeat while held. It sits between the per-button debounce instance and the clock set/mode controller, with one instance per button.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time in clock cycles before a press counts as long; legal range ≥2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period in clock cycles after a long press; legal range ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_ff`  in  1  debounced button level; 1 = pressed.
- `valid_pulse`  in  1  one-cycle pulse from debounce marking press start.
- `short_pulse`  out  1  one cycle; press released before the long threshold.
- `long_pulse`  out  1  one cycle; long threshold reached while still held.
- `repeat_pulse`  out  1  one cycle; periodic while held after a long press.
- `long_held`  out  1  level; high while in LONG state.

## Operation
- States: IDLE, PRESSED, LONG.
- Counter `cnt`, width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)); unsigned; never wraps, because it is cleared before reaching its limit.
- IDLE: if `valid_pulse` is high, go to PRESSED with `cnt`=0. A high `valid_ff` without `valid_pulse` is ignored.
- PRESSED, `valid_ff`=0: assert `short_pulse` and go to IDLE.
- PRESSED, `valid_ff`=1 and `cnt`==LONG_CYCLES-1: assert `long_pulse`, go to LONG, set `cnt`=0.
- PRESSED, otherwise: increment `cnt`.
- LONG, `valid_ff`=0: go to IDLE with no pulse.
- LONG, `cnt`==REPEAT_CYCLES-1: assert `repeat_pulse` and set `cnt`=0.
- LONG, otherwise: increment `cnt`.
- Simultaneous events:
  - Release and threshold on the same edge: release wins, so the press is short.
  - `valid_pulse` while in PRESSED or LONG: ignored, and `cnt` is not restarted.
- The three pulse outputs are mutually exclusive. Each is high for exactly one cycle per event.

## Timing
- All outputs are registered.
- Reset values: `short_pulse`=0, `long_pulse`=0, `repeat_pulse`=0, `long_held`=0; state IDLE; `cnt`=0.
- Let E0 be the edge that samples `valid_pulse`=1 in IDLE.
- Long press: `long_pulse` is high in the cycle after edge E0+LONG_CYCLES, provided `valid_ff`=1 at edges E1..E0+LONG_CYCLES.
- Short press: release first sampled at edge Ek, with 1≤k≤LONG_CYCLES, gives `short_pulse` high in the cycle after Ek.
- Auto-repeat: the first `repeat_pulse` follows edge E0+LONG_CYCLES+REPEAT_CYCLES, then one every REPEAT_CYCLES cycles.
- `long_held` rises together with `long_pulse`. It falls in the cycle after the edge that samples the release.
- Reset mid-operation: everything returns to the reset values immediately. A button still held after reset deasserts generates no event until a new `valid_pulse` arrives.
- A new press is accepted in the first cycle after returning to IDLE.

## Configuration
- Macro: `BUTTON_EVENT_REPEAT_EN`.
- Defined: auto-repeat works as described above.
- Undefined:
  - `repeat_pulse` is tied to 0.
  - LONG only waits for release, and `cnt` holds at 0.
  - `REPEAT_CYCLES` is ignored, and the counter width is $clog2(LONG_CYCLES).

## Structure
- Shared package `button_event_pkg` holds:
  - enum typedef `btn_state_t` {IDLE, PRESSED, LONG};
  - default timing constants `BTN_LONG_CYCLES_DEF` and `BTN_REPEAT_CYCLES_DEF`.
- Single module with no sub-module. The counter and FSM are too tightly coupled to split.

## Test plan
Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4; `clk` period 20 ns.
- Reset, then idle 10 cycles with inputs low -> all outputs remain 0.
- `valid_pulse` plus hold 3 cycles, then release -> exactly one `short_pulse`, no `long_pulse`.
- Hold 20 cycles after `valid_pulse` -> `long_pulse` after edge E0+8, and `repeat_pulse` after E0+12, E0+16 and E0+20.
  - `long_held` is high from E0+8 until release.
  - With `BUTTON_EVENT_REPEAT_EN` undefined, no `repeat_pulse` occurs.
- Release first sampled at E0+8 -> `short_pulse` only; the release beats the threshold.
- Assert `rst` at E0+5 while held, deassert with button still held -> all outputs stay 0 and no event occurs.
  - A new `valid_pulse` after release is then decoded normally.
- Extra `valid_pulse` at E0+4 during a hold -> ignored; `long_pulse` is still at E0+8.
